// File: rtl/jtvigil_sndlatch.sv
// Main-to-sound CPU command channel: CH FIFOs written by the main CPU, popped by
// the sound CPU, plus the sound-CPU interrupt and a stretched sound-CPU reset.

module jtvigil_sndlatch_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 1,
    parameter int OVR   = 1,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_head,
    output logic [CW-1:0] o_cnt
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_last;
    logic          w_full, w_pop_ok, w_store, w_ovw;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (DEPTH == 1) ? '0 : AW'(p + 1'b1);
    endfunction

    assign w_full   = (r_cnt == CW'(DEPTH));
    assign w_pop_ok = i_pop & (r_cnt != '0);
    // a pop in the same cycle frees a slot, so a push on a full FIFO still lands
    assign w_store  = i_push & (~w_full | w_pop_ok);
    assign w_ovw    = i_push & w_full & ~w_pop_ok & (OVR != 0);
    assign w_last   = (DEPTH == 1) ? '0 : AW'(r_wptr - 1'b1);
    assign o_head   = r_mem[r_rptr];
    assign o_cnt    = r_cnt;

    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (w_store)     r_mem[r_wptr] <= i_din;
            else if (w_ovw)  r_mem[w_last] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_pop_ok) r_rptr <= inc(r_rptr);
            if (w_store)  r_wptr <= inc(r_wptr);
            if (w_store && !w_pop_ok)      r_cnt <= r_cnt + 1'b1;
            else if (!w_store && w_pop_ok) r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

module jtvigil_sndlatch #(
    parameter int CH      = 2,
    parameter int DW      = 8,
    parameter int DEPTH   = 1,
    parameter int OVR     = 1,
    parameter int RST_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            main_we,
    input  logic [1:0]      main_sel,
    input  logic [DW-1:0]   main_din,
    input  logic            sres_we,
    input  logic            sres_din,
    output logic [2*CH-1:0] main_st,
    input  logic            snd_rd,
    input  logic [1:0]      snd_sel,
    output logic [DW-1:0]   snd_dout,
    output logic            snd_int,
    output logic            sres_b
);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int SCW  = $clog2(RST_CYC + 1);

    logic [CH-1:0][DW-1:0] w_head;
    logic [CH-1:0][CW-1:0] w_cnt;
    logic [CH-1:0]         w_push, w_pop, w_ne, w_full;
    logic                  w_flush, w_req_nxt, w_sres_nxt;
    logic [SCW-1:0]        w_scnt_nxt;
    logic [DW-1:0]         w_dout_nxt;

    logic                  r_sres_b, r_req, r_int;
    logic [SCW-1:0]        r_scnt;
    logic [DW-1:0]         r_dout;

    assign w_flush = cen & sres_we & ~sres_din;

    genvar c;
    generate
        for (c = 0; c < CH; c++) begin : g_ch
            assign w_push[c] = cen & main_we & (int'(main_sel) == c);
            assign w_pop[c]  = cen & snd_rd & r_sres_b & (int'(snd_sel) == c);
            assign w_ne[c]   = (w_cnt[c] != '0);
            assign w_full[c] = (w_cnt[c] == CW'(DEPTH));

            jtvigil_sndlatch_fifo #(.DW(DW), .DEPTH(DEPTH), .OVR(OVR)) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (w_flush),
                .i_push  (w_push[c]),
                .i_pop   (w_pop[c]),
                .i_din   (main_din),
                .o_head  (w_head[c]),
                .o_cnt   (w_cnt[c])
            );
        end
    endgenerate

    assign main_st = {w_full, w_ne};

    always_comb begin
        w_dout_nxt = r_dout;
        for (int i = 0; i < CH; i++)
            if (w_pop[i] && w_ne[i]) w_dout_nxt = w_head[i];
    end

    // release fires on the cen edge where the counter reaches zero
    always_comb begin
        w_req_nxt  = w_flush ? 1'b0 : (r_req | (cen & sres_we & sres_din));
        w_sres_nxt = r_sres_b;
        w_scnt_nxt = r_scnt;
        if (w_flush) begin
            w_sres_nxt = 1'b0;
            w_scnt_nxt = SCW'(RST_CYC);
        end else if (cen && !r_sres_b) begin
            w_scnt_nxt = (r_scnt == '0) ? '0 : r_scnt - 1'b1;
            if (w_scnt_nxt == '0 && w_req_nxt) w_sres_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sres_b <= 1'b0;
            r_scnt   <= SCW'(RST_CYC);
            r_req    <= 1'b1;
            r_int    <= 1'b0;
            r_dout   <= '0;
        end else if (cen) begin
            r_sres_b <= w_sres_nxt;
            r_scnt   <= w_scnt_nxt;
            r_req    <= w_req_nxt;
            r_int    <= w_sres_nxt & (|w_ne);
            r_dout   <= w_dout_nxt;
        end
    end

    assign snd_dout = r_dout;
    assign snd_int  = r_int;
    assign sres_b   = r_sres_b;
endmodule
